// File: rtl/scp_pkg.sv
// Shared types and default widths for the scratchpad memory arbiter.
package scp_pkg;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    IFU = 2'd0,
    DMU = 2'd1,
    DBG = 2'd2
  } req_id_e;

endpackage

// File: rtl/scp_rr_arb2.sv
// Two-way round-robin between instruction fetch and data access.
// The pointer remembers which side won last; the other side wins a tie.
module scp_rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic req_ifu,
  input  logic req_dmu,
  input  logic advance,
  output logic gnt_ifu,
  output logic gnt_dmu
);

  // Reset value 1 ("dmu won last") so the first tie goes to ifu.
  logic last_dmu_q, last_dmu_d;

  // Grant: a lone requester wins outright, a tie goes to the side not served last.
  always_comb begin
    gnt_ifu = 1'b0;
    gnt_dmu = 1'b0;
    if (req_ifu && req_dmu) begin
      gnt_ifu = last_dmu_q;
      gnt_dmu = !last_dmu_q;
    end else begin
      gnt_ifu = req_ifu;
      gnt_dmu = req_dmu;
    end
  end

  // Pointer moves only when the parent commits an ifu/dmu grant.
  always_comb begin
    last_dmu_d = last_dmu_q;
    if (advance && (gnt_ifu || gnt_dmu)) begin
      last_dmu_d = gnt_dmu;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_dmu_q <= 1'b1;
    end else begin
      last_dmu_q <= last_dmu_d;
    end
  end

endmodule

// File: rtl/scp_mem_arbiter.sv
// Arbitrates fetch, data and debug masters onto one single-port memory.
// One access in flight at a time: IDLE grants, ISSUE waits for mem_rdy
// (or times out), RESP returns a one-cycle ack to the granted master.
module scp_mem_arbiter
  import scp_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_ack,
  output logic [DATA_W-1:0]   ifu_rdata,
  input  logic                dmu_req,
  input  logic                dmu_we,
  input  logic [ADDR_W-1:0]   dmu_addr,
  input  logic [DATA_W-1:0]   dmu_wdata,
  input  logic [DATA_W/8-1:0] dmu_be,
  output logic                dmu_ack,
  output logic [DATA_W-1:0]   dmu_rdata,
  input  logic                dbg_req,
  input  logic                dbg_we,
  input  logic [ADDR_W-1:0]   dbg_addr,
  input  logic [DATA_W-1:0]   dbg_wdata,
  output logic                dbg_ack,
  output logic [DATA_W-1:0]   dbg_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_rdy,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic                err
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  req_id_e             id_q, id_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   ifu_rdata_q, ifu_rdata_d;
  logic [DATA_W-1:0]   dmu_rdata_q, dmu_rdata_d;
  logic [DATA_W-1:0]   dbg_rdata_q, dbg_rdata_d;

  logic                gnt_ifu, gnt_dmu;
  logic                rd_load;
  logic [DATA_W-1:0]   rd_val;

  // Debug overrides the round-robin, so the pointer only advances when dbg is quiet.
  scp_rr_arb2 u_rr (
    .clk     (clk),
    .rst     (rst),
    .req_ifu (ifu_req),
    .req_dmu (dmu_req),
    .advance ((state_q == IDLE) && !dbg_req),
    .gnt_ifu (gnt_ifu),
    .gnt_dmu (gnt_dmu)
  );

  // Next-state, command capture, timeout count and read-data capture.
  // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    cnt_d       = cnt_q;
    err_d       = 1'b0;
    ifu_rdata_d = ifu_rdata_q;
    dmu_rdata_d = dmu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    rd_load     = 1'b0;
    rd_val      = '0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (dbg_req) begin
          id_d    = DBG;
          we_d    = dbg_we;
          addr_d  = dbg_addr;
          wdata_d = dbg_wdata;
          be_d    = '1;
          state_d = ISSUE;
        end else if (gnt_ifu) begin
          id_d    = IFU;
          we_d    = 1'b0;
          addr_d  = ifu_addr;
          wdata_d = '0;
          be_d    = '1;
          state_d = ISSUE;
        end else if (gnt_dmu) begin
          id_d    = DMU;
          we_d    = dmu_we;
          addr_d  = dmu_addr;
          wdata_d = dmu_wdata;
          be_d    = dmu_be;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_rdy) begin
          rd_load = 1'b1;
          rd_val  = we_q ? '0 : mem_rdata;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rd_load = 1'b1;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (rd_load) begin
      case (id_q)
        IFU:     ifu_rdata_d = rd_val;
        DMU:     dmu_rdata_d = rd_val;
        default: dbg_rdata_d = rd_val;
      endcase
    end
  end

  // State and datapath registers; reset abandons any access in flight.
  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      id_q        <= IFU;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      ifu_rdata_q <= '0;
      dmu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      ifu_rdata_q <= ifu_rdata_d;
      dmu_rdata_q <= dmu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  // Outputs decode straight from state, so reset drops mem_req and acks at once.
  assign mem_req   = (state_q == ISSUE);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;
  assign busy      = (state_q != IDLE);
  assign err       = (state_q == RESP) && err_q;
  assign ifu_ack   = (state_q == RESP) && (id_q == IFU);
  assign dmu_ack   = (state_q == RESP) && (id_q == DMU);
  assign dbg_ack   = (state_q == RESP) && (id_q == DBG);
  assign ifu_rdata = ifu_rdata_q;
  assign dmu_rdata = dmu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_scp_mem_arbiter.sv
// Directed bench for scp_mem_arbiter: a table of single-master accesses plus
// hand-written arbitration, rdata-hold and mid-access reset sequences.
module tb_scp_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req, dmu_req, dbg_req, dmu_we, dbg_we;
  logic [31:0] ifu_addr, dmu_addr, dbg_addr, dmu_wdata, dbg_wdata;
  logic [3:0]  dmu_be;
  logic        ifu_ack, dmu_ack, dbg_ack;
  logic [31:0] ifu_rdata, dmu_rdata, dbg_rdata;
  logic        mem_req, mem_we, mem_rdy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        busy, err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  scp_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_ack(ifu_ack), .ifu_rdata(ifu_rdata),
    .dmu_req(dmu_req), .dmu_we(dmu_we), .dmu_addr(dmu_addr), .dmu_wdata(dmu_wdata),
    .dmu_be(dmu_be), .dmu_ack(dmu_ack), .dmu_rdata(dmu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdy(mem_rdy), .mem_rdata(mem_rdata),
    .busy(busy), .err(err)
  );

  typedef struct {
    string       name;
    logic [2:0]  req;        // {dbg, dmu, ifu}
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          rdy_delay;  // ISSUE cycles before mem_rdy; >= TIMEOUT means never
    logic [31:0] mem_data;
    logic [3:0]  exp_be;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;    // cycles from req assertion (cycle 1) to ack
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rdata_of(input logic [2:0] a);
    case (a)
      3'b001:  return ifu_rdata;
      3'b010:  return dmu_rdata;
      default: return dbg_rdata;
    endcase
  endfunction

  // Called at a negedge in the cycle where the expected request is (or was) visible.
  // Plays the memory: fields are checked on the first ISSUE cycle and must stay
  // stable; mem_rdy is returned after rdy_delay ISSUE cycles.
  task automatic wait_ack(input string name, input logic [2:0] exp_ack,
                          input logic [31:0] exp_addr, input logic exp_we,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input int exp_lat, input int rdy_delay,
                          input logic [31:0] mem_data);
    int cyc = 1;
    int issue_n = 0;
    bit done = 0;
    bit stable = 1;
    logic [2:0] ack;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      mem_rdy   = 1'b0;
      mem_rdata = 32'hBAD0_BAD0;
      ack = {dbg_ack, dmu_ack, ifu_ack};
      if (ack != 3'b000) begin
        done = 1;
        check({name, " ack"}, {29'd0, ack}, {29'd0, exp_ack});
        check({name, " rdata"}, rdata_of(exp_ack), exp_rdata);
        check({name, " err"}, {31'd0, err}, {31'd0, exp_err});
        check({name, " latency"}, cyc, exp_lat);
        check({name, " mem_req dropped"}, {31'd0, mem_req}, 32'd0);
        check({name, " cmd stable"}, {31'd0, stable}, 32'd1);
      end else if (mem_req) begin
        if (issue_n == 0) begin
          check({name, " mem_addr"}, mem_addr, exp_addr);
          check({name, " mem_we"}, {31'd0, mem_we}, {31'd0, exp_we});
          check({name, " mem_be"}, {28'd0, mem_be}, {28'd0, exp_be});
          if (exp_we) check({name, " mem_wdata"}, mem_wdata, exp_wdata);
        end else if (mem_addr !== exp_addr || mem_we !== exp_we || mem_be !== exp_be) begin
          stable = 0;
        end
        if (issue_n == rdy_delay) begin
          mem_rdy   = 1'b1;
          mem_rdata = mem_data;
        end
        issue_n++;
      end
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: no ack within 60 cycles, required ack 0x%0h", name, exp_ack);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    ifu_req = 0; dmu_req = 0; dbg_req = 0; dmu_we = 0; dbg_we = 0;
    ifu_addr = 0; dmu_addr = 0; dbg_addr = 0; dmu_wdata = 0; dbg_wdata = 0;
    dmu_be = 4'hF; mem_rdy = 0; mem_rdata = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    tbl[0] = '{"ifu_fetch",  3'b001, 1'b0, 32'h40,  32'h0,         4'hF, 0,  32'h8C41_0004, 4'hF,   32'h8C41_0004, 1'b0, 3};
    tbl[1] = '{"dmu_store",  3'b010, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'h3, 2,  32'hFFFF_FFFF, 4'h3,   32'h0,         1'b0, 5};
    tbl[2] = '{"dmu_load",   3'b010, 1'b0, 32'h200, 32'h0,         4'hF, 1,  32'h1234_5678, 4'hF,   32'h1234_5678, 1'b0, 4};
    tbl[3] = '{"dbg_write",  3'b100, 1'b1, 32'h300, 32'hCAFE_F00D, 4'h0, 0,  32'hFFFF_FFFF, 4'hF,   32'h0,         1'b0, 3};
    tbl[4] = '{"dbg_read",   3'b100, 1'b0, 32'h304, 32'h0,         4'h0, 3,  32'hA5A5_5A5A, 4'hF,   32'hA5A5_5A5A, 1'b0, 6};
    tbl[5] = '{"dmu_timeout",3'b010, 1'b0, 32'h400, 32'h0,         4'hF, 99, 32'h7777_7777, 4'hF,   32'h0,         1'b1, 18};
    tbl[6] = '{"ifu_rdy_last",3'b001,1'b0, 32'h44,  32'h0,         4'h0, 15, 32'h600D_F00D, 4'hF,   32'h600D_F00D, 1'b0, 18};

    // Reset state.
    do_reset();
    rst = 1'b0;
    @(negedge clk);
    check("reset mem_req", {31'd0, mem_req}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset err", {31'd0, err}, 32'd0);
    check("reset acks", {29'd0, dbg_ack, dmu_ack, ifu_ack}, 32'd0);
    check("reset ifu_rdata", ifu_rdata, 32'd0);
    check("reset dmu_rdata", dmu_rdata, 32'd0);
    check("reset dbg_rdata", dbg_rdata, 32'd0);
    rst = 1'b1;

    // ifu and dmu both request continuously: grants alternate starting with ifu.
    @(negedge clk);
    ifu_addr = 32'h1000; dmu_addr = 32'h2000; dmu_be = 4'hF;
    ifu_req = 1; dmu_req = 1;
    wait_ack("rr1 ifu", 3'b001, 32'h1000, 1'b0, 4'hF, 32'h0, 32'h0000_1111, 1'b0, 3, 0, 32'h0000_1111);
    wait_ack("rr2 dmu", 3'b010, 32'h2000, 1'b0, 4'hF, 32'h0, 32'h0000_2222, 1'b0, 4, 0, 32'h0000_2222);
    wait_ack("rr3 ifu", 3'b001, 32'h1000, 1'b0, 4'hF, 32'h0, 32'h0000_3333, 1'b0, 4, 0, 32'h0000_3333);
    wait_ack("rr4 dmu", 3'b010, 32'h2000, 1'b0, 4'hF, 32'h0, 32'h0000_4444, 1'b0, 4, 0, 32'h0000_4444);
    ifu_req = 0; dmu_req = 0;

    // All three together after reset: dbg, then ifu, then dmu.
    do_reset();
    @(negedge clk);
    ifu_addr = 32'h1000; dmu_addr = 32'h2000; dbg_addr = 32'h3000;
    ifu_req = 1; dmu_req = 1; dbg_req = 1;
    wait_ack("all3 dbg", 3'b100, 32'h3000, 1'b0, 4'hF, 32'h0, 32'h0D0D_0001, 1'b0, 3, 0, 32'h0D0D_0001);
    dbg_req = 0;
    wait_ack("all3 ifu", 3'b001, 32'h1000, 1'b0, 4'hF, 32'h0, 32'h0D0D_0002, 1'b0, 4, 0, 32'h0D0D_0002);
    ifu_req = 0;
    wait_ack("all3 dmu", 3'b010, 32'h2000, 1'b0, 4'hF, 32'h0, 32'h0D0D_0003, 1'b0, 4, 0, 32'h0D0D_0003);
    dmu_req = 0;

    // Pointer favouring dmu must survive an intervening dbg grant.
    @(negedge clk);
    ifu_req = 1;
    wait_ack("ptr ifu", 3'b001, 32'h1000, 1'b0, 4'hF, 32'h0, 32'h0E0E_0001, 1'b0, 3, 0, 32'h0E0E_0001);
    ifu_req = 0;
    @(negedge clk);
    ifu_req = 1; dmu_req = 1; dbg_req = 1;
    wait_ack("ptr dbg", 3'b100, 32'h3000, 1'b0, 4'hF, 32'h0, 32'h0E0E_0002, 1'b0, 3, 0, 32'h0E0E_0002);
    dbg_req = 0;
    wait_ack("ptr dmu", 3'b010, 32'h2000, 1'b0, 4'hF, 32'h0, 32'h0E0E_0003, 1'b0, 4, 0, 32'h0E0E_0003);
    dmu_req = 0;
    wait_ack("ptr ifu2", 3'b001, 32'h1000, 1'b0, 4'hF, 32'h0, 32'h0E0E_0004, 1'b0, 4, 0, 32'h0E0E_0004);
    ifu_req = 0;

    // mem_rdy while idle is ignored.
    @(negedge clk);
    mem_rdy = 1; mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    mem_rdy = 0;
    @(negedge clk);
    check("stray rdy busy", {31'd0, busy}, 32'd0);
    check("stray rdy acks", {29'd0, dbg_ack, dmu_ack, ifu_ack}, 32'd0);
    check("stray rdy dmu_rdata", dmu_rdata, 32'h0E0E_0003);

    // Single-master table.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check({tbl[i].name, " idle before"}, {31'd0, busy}, 32'd0);
      ifu_req = tbl[i].req[0]; ifu_addr = tbl[i].addr;
      dmu_req = tbl[i].req[1]; dmu_addr = tbl[i].addr; dmu_we = tbl[i].we;
      dmu_wdata = tbl[i].wdata; dmu_be = tbl[i].be;
      dbg_req = tbl[i].req[2]; dbg_addr = tbl[i].addr; dbg_we = tbl[i].we;
      dbg_wdata = tbl[i].wdata;
      wait_ack(tbl[i].name, tbl[i].req, tbl[i].addr, tbl[i].req[0] ? 1'b0 : tbl[i].we,
               tbl[i].exp_be, tbl[i].wdata, tbl[i].exp_rdata, tbl[i].exp_err,
               tbl[i].exp_lat, tbl[i].rdy_delay, tbl[i].mem_data);
      ifu_req = 0; dmu_req = 0; dbg_req = 0;
    end

    // rdata outputs hold their last values between acks.
    @(negedge clk);
    check("hold ifu_rdata", ifu_rdata, 32'h600D_F00D);
    check("hold dmu_rdata", dmu_rdata, 32'h0);
    check("hold dbg_rdata", dbg_rdata, 32'hA5A5_5A5A);
    check("hold err low", {31'd0, err}, 32'd0);

    // Reset in the middle of ISSUE abandons the access.
    ifu_addr = 32'h500; ifu_req = 1;
    @(negedge clk);
    check("midrst in issue", {31'd0, mem_req}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("midrst mem_req", {31'd0, mem_req}, 32'd0);
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst acks", {29'd0, dbg_ack, dmu_ack, ifu_ack}, 32'd0);
    check("midrst ifu_rdata", ifu_rdata, 32'd0);
    ifu_req = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("postrst no ack", {29'd0, dbg_ack, dmu_ack, ifu_ack}, 32'd0);
    ifu_addr = 32'h600; ifu_req = 1;
    wait_ack("postrst ifu", 3'b001, 32'h600, 1'b0, 4'hF, 32'h0, 32'h1111_2222, 1'b0, 3, 0, 32'h1111_2222);
    ifu_req = 0;

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
